// File: rtl/rgb_pkg.sv
// rgb_pkg: FSM state encodings, colour indices and the colour-rotation helper for the RGB PWM sequencer.
package rgb_pkg;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RAMP_UP   = 3'd1;
    localparam logic [2:0] HOLD      = 3'd2;
    localparam logic [2:0] RAMP_DOWN = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    localparam logic [1:0] COL_RED   = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_BLUE  = 2'd2;

    // Nearest enabled colour after cur, cyclically; cur itself if it is the only one set.
    function automatic logic [1:0] next_color(input logic [1:0] cur, input logic [2:0] mask);
        logic [1:0] c;
        next_color = cur;
        for (int k = 3; k >= 1; k--) begin
            c = 2'((int'(cur) + k) % 3);
            if (mask[c]) next_color = c;
        end
    endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: tick prescaler and free-running PWM counter, both held at zero while clr_i is high.
module pwm_tick_gen #(
    parameter int TICK_DIV = 12,
    parameter int PWM_BITS = 8
) (
    input  logic                hw_clk,
    input  logic                rst,
    input  logic                clr_i,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                period_end_o
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]       pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    assign tick_o       = !clr_i && pre_q == PRE_MAX;
    assign period_end_o = tick_o && &cnt_q;
    assign pwm_cnt_o    = cnt_q;

    always_comb begin
        pre_d = (clr_i || tick_o) ? '0 : pre_q + 1'b1;
        cnt_d = clr_i ? '0 : cnt_q + PWM_BITS'(tick_o);
    end

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: breathing RGB sequence (ramp up, hold, ramp down, gap) per enabled colour,
// driving registered PWM outputs for the SB_RGBA_DRV pins.
module rgb_pwm_sequencer
    import rgb_pkg::*;
#(
    parameter int TICK_DIV     = 12,
    parameter int PWM_BITS     = 8,
    parameter int STEP         = 1,
    parameter int HOLD_PERIODS = 64,
    parameter int GAP_PERIODS  = 32
) (
    input  logic       hw_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] color_mask,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue,
    output logic [1:0] active_color,
    output logic       busy
);
    localparam int MAX_I  = (1 << PWM_BITS) - 1;
    localparam int STEP_C = STEP > MAX_I ? MAX_I : STEP;
    localparam int PMAX   = HOLD_PERIODS > GAP_PERIODS ? HOLD_PERIODS : GAP_PERIODS;
    localparam int CNT_W  = $clog2(PMAX + 1);
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(STEP_C);
    localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP_C);
    localparam logic [CNT_W-1:0]    HOLD_N = CNT_W'(HOLD_PERIODS);
    localparam logic [CNT_W-1:0]    GAP_N  = CNT_W'(GAP_PERIODS);

    logic [2:0]          state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]    per_q, per_d;
    logic [1:0]          col_q, col_d;
    logic [2:0]          pwm_q, pwm_d;

    logic                tick, period_end, pe, on;
    logic [PWM_BITS-1:0] pwm_cnt, up_duty, dn_duty;
    logic [PWM_BITS:0]   up_sum;
    logic [CNT_W-1:0]    per_inc;

    pwm_tick_gen #(.TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS)) u_tick (
        .hw_clk       (hw_clk),
        .rst          (rst),
        .clr_i        (state_q == IDLE || !enable),
        .tick_o       (tick),
        .pwm_cnt_o    (pwm_cnt),
        .period_end_o (period_end)
    );

    assign pe      = tick && period_end;
    assign up_sum  = {1'b0, duty_q} + STEP_W;
    assign up_duty = up_sum > {1'b0, MAX} ? MAX : up_sum[PWM_BITS-1:0];
    assign dn_duty = duty_q < STEP_N ? '0 : duty_q - STEP_N;
    assign per_inc = per_q + 1'b1;
    assign on      = enable && (state_q == RAMP_UP || state_q == HOLD || state_q == RAMP_DOWN) && pwm_cnt < duty_q;
    assign pwm_d   = {3{on}} & {col_q == COL_BLUE, col_q == COL_GREEN, col_q == COL_RED};

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        per_d   = per_q;
        col_d   = col_q;
        if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
            per_d   = '0;
            col_d   = COL_RED;
        end else begin
            case (state_q)
                IDLE: if (|color_mask) begin
                    state_d = RAMP_UP;
                    duty_d  = '0;
                    per_d   = '0;
                    col_d   = next_color(COL_BLUE, color_mask);
                end
                RAMP_UP: if (pe) begin
                    duty_d = up_duty;
                    if (up_duty == MAX) begin
                        state_d = HOLD;
                        per_d   = '0;
                    end
                end
                HOLD: if (pe) begin
                    per_d = per_inc;
                    if (per_inc == HOLD_N) begin
                        state_d = RAMP_DOWN;
                        per_d   = '0;
                    end
                end
                RAMP_DOWN: if (pe) begin
                    duty_d = dn_duty;
                    if (dn_duty == '0) begin
                        state_d = GAP;
                        per_d   = '0;
                    end
                end
                GAP: if (pe) begin
                    per_d = per_inc;
                    if (per_inc == GAP_N) begin
                        // Mask is only looked at here, so mid-colour changes wait for the gap to finish.
                        per_d   = '0;
                        duty_d  = '0;
                        state_d = |color_mask ? RAMP_UP : IDLE;
                        col_d   = |color_mask ? next_color(col_q, color_mask) : col_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            per_q   <= '0;
            col_q   <= COL_RED;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            per_q   <= per_d;
            col_q   <= col_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_red      = pwm_q[COL_RED];
    assign pwm_green    = pwm_q[COL_GREEN];
    assign pwm_blue     = pwm_q[COL_BLUE];
    assign active_color = col_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: scoreboard bench; stimulus queues expected per-period PWM patterns,
// monitors rebuild each 16-cycle period from the outputs and compare.
module tb_rgb_pwm_sequencer;
    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        logic [1:0]  col;
        logic        busy;
    } exp_t;

    localparam int FULL [11] = '{0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};
    localparam int SAT  [9]  = '{0, 5, 10, 15, 15, 15, 10, 5, 0};

    logic       hw_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       en5 = 1'b0;
    logic [2:0] color_mask = 3'b001;
    logic [2:0] mask5 = 3'b001;
    logic       pwm_red, pwm_green, pwm_blue, busy;
    logic       r5, g5, b5, busy5;
    logic [1:0] active_color, col5;
    exp_t       q0[$];
    exp_t       q1[$];
    int         checks = 0;
    int         failures = 0;

    always #5 hw_clk = ~hw_clk;

    rgb_pwm_sequencer #(.TICK_DIV(1), .PWM_BITS(4), .STEP(4), .HOLD_PERIODS(2), .GAP_PERIODS(1)) dut (
        .hw_clk(hw_clk), .rst(rst), .enable(enable), .color_mask(color_mask),
        .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
        .active_color(active_color), .busy(busy)
    );

    rgb_pwm_sequencer #(.TICK_DIV(1), .PWM_BITS(4), .STEP(5), .HOLD_PERIODS(2), .GAP_PERIODS(1)) dut5 (
        .hw_clk(hw_clk), .rst(rst), .enable(en5), .color_mask(mask5),
        .pwm_red(r5), .pwm_green(g5), .pwm_blue(b5),
        .active_color(col5), .busy(busy5)
    );

    function automatic logic [15:0] dv(input int d);
        return 16'((32'd1 << d) - 1);
    endfunction

    function automatic int qsize(input int id);
        return id == 0 ? q0.size() : q1.size();
    endfunction

    task automatic push_seq(input int id, input logic [1:0] col, input int n, input bit sat);
        exp_t e;
        int d;
        for (int i = 0; i < n; i++) begin
            d      = sat ? SAT[i] : FULL[i];
            e.r    = col == 2'd0 ? dv(d) : 16'h0;
            e.g    = col == 2'd1 ? dv(d) : 16'h0;
            e.b    = col == 2'd2 ? dv(d) : 16'h0;
            e.col  = col;
            e.busy = 1'b1;
            if (id == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input int id, input int k, input string name);
        int n;
        n = 0;
        while (qsize(id) > k && n < 600) begin
            @(posedge hw_clk);
            n++;
        end
        checks++;
        if (qsize(id) > k) begin
            failures++;
            $display("FAIL %s: timeout with %0d periods pending, required %0d", name, qsize(id), k);
            if (id == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic restart(input logic [2:0] m);
        repeat (2) @(posedge hw_clk);
        #1 color_mask = m;
        enable = 1'b1;
    endtask

    task automatic monitor(input int id);
        int         ph;
        logic [3:0] idx;
        logic       pr, pg, pb, bz;
        logic [1:0] ac;
        exp_t       o, e;
        ph = -1;
        o  = '0;
        forever begin
            @(negedge hw_clk);
            pr = id == 0 ? pwm_red : r5;
            pg = id == 0 ? pwm_green : g5;
            pb = id == 0 ? pwm_blue : b5;
            bz = id == 0 ? busy : busy5;
            ac = id == 0 ? active_color : col5;
            if (rst) begin
                ph = -1;
            end else begin
                if (ph >= 1) begin
                    idx = 4'((ph - 1) % 16);
                    o.r[idx] = pr;
                    o.g[idx] = pg;
                    o.b[idx] = pb;
                    if (ph % 16 == 8) begin
                        o.col  = ac;
                        o.busy = bz;
                    end
                    if (idx == 4'd15) begin
                        checks++;
                        if (qsize(id) == 0) begin
                            failures++;
                            $display("FAIL dut%0d period: unexpected period r=%h g=%h b=%h col=%0d", id, o.r, o.g, o.b, o.col);
                        end else begin
                            if (id == 0) e = q0.pop_front();
                            else e = q1.pop_front();
                            if (o !== e) begin
                                failures++;
                                $display("FAIL dut%0d period: got r=%h g=%h b=%h col=%0d busy=%b, expected r=%h g=%h b=%h col=%0d busy=%b",
                                         id, o.r, o.g, o.b, o.col, o.busy, e.r, e.g, e.b, e.col, e.busy);
                            end
                        end
                        o = '0;
                    end
                end
                if (ph >= 0 && !bz) begin
                    ph = -1;
                    o  = '0;
                end else if (ph < 0 && bz) begin
                    ph = 0;
                end
                if (ph >= 0) ph++;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) begin
            @(negedge hw_clk);
            chk("reset", {2'b00, pwm_red, pwm_green, pwm_blue, busy, active_color}, 8'h00);
        end
        // Red only: full cycle plus the first two periods of the restart.
        push_seq(0, 2'd0, 11, 1'b0);
        push_seq(0, 2'd0, 2, 1'b0);
        @(posedge hw_clk);
        #1 rst = 1'b0;
        drain(0, 0, "red_only");
        #1 enable = 1'b0;
        @(posedge hw_clk);
        @(negedge hw_clk);
        chk("enable_drop", {4'h0, pwm_red, pwm_green, pwm_blue, busy}, 8'h00);
        @(negedge hw_clk);
        chk("enable_low_idle", {4'h0, pwm_red, pwm_green, pwm_blue, busy}, 8'h00);
        push_seq(0, 2'd0, 3, 1'b0);
        restart(3'b001);
        drain(0, 0, "reenable");
        #1 enable = 1'b0;
        push_seq(0, 2'd0, 11, 1'b0);
        push_seq(0, 2'd2, 11, 1'b0);
        push_seq(0, 2'd0, 2, 1'b0);
        restart(3'b101);
        drain(0, 0, "mask_101");
        #1 enable = 1'b0;
        push_seq(0, 2'd0, 11, 1'b0);
        push_seq(0, 2'd1, 2, 1'b0);
        restart(3'b001);
        drain(0, 8, "reach_hold");
        #1 color_mask = 3'b010;
        drain(0, 0, "mask_to_green");
        #1 enable = 1'b0;
        push_seq(0, 2'd0, 11, 1'b0);
        restart(3'b001);
        drain(0, 6, "reach_hold2");
        #1 color_mask = 3'b000;
        drain(0, 0, "mask_clear");
        @(negedge hw_clk);
        chk("idle_after_gap", {4'h0, pwm_red, pwm_green, pwm_blue, busy}, 8'h00);
        repeat (20) @(negedge hw_clk);
        chk("idle_stays", {4'h0, pwm_red, pwm_green, pwm_blue, busy}, 8'h00);
        @(posedge hw_clk);
        #1 enable = 1'b0;
        push_seq(1, 2'd0, 9, 1'b1);
        @(posedge hw_clk);
        #1 en5 = 1'b1;
        drain(1, 0, "saturation");
        #1 en5 = 1'b0;
        repeat (4) @(posedge hw_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
